// File: rtl/iir_order2_ctrl.sv
// Second-order IIR section with a handshake front end and double-buffered
// coefficients. The arithmetic lives in the combinational iir_order2 core.
// The controller sequences samples through IDLE/CALC/OUT, owns the delay line,
// and swaps in the shadow coefficient bank only between samples.

// Combinational biquad datapath:
//   y0 = sat(round((b0*x0 + b1*x1 + b2*x2 + a1*y1 + a2*y2) / 2^(CWIDTH-3)))
// Coefficients are fixed point with unity at 2^(CWIDTH-3). Rounding is half-up.
// The feedback terms are added, so a1/a2 carry whatever sign the designer wants.
module iir_order2 #(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 24
) (
    input  logic signed [DWIDTH-1:0] x0,
    input  logic signed [DWIDTH-1:0] x1,
    input  logic signed [DWIDTH-1:0] x2,
    input  logic signed [DWIDTH-1:0] y1,
    input  logic signed [DWIDTH-1:0] y2,
    input  logic signed [CWIDTH-1:0] b0,
    input  logic signed [CWIDTH-1:0] b1,
    input  logic signed [CWIDTH-1:0] b2,
    input  logic signed [CWIDTH-1:0] a1,
    input  logic signed [CWIDTH-1:0] a2,
    output logic signed [DWIDTH-1:0] y0
);
    // Three guard bits cover the sum of five full-scale products.
    localparam int AW   = DWIDTH + CWIDTH + 3;
    localparam int FRAC = CWIDTH - 3;
    localparam logic signed [AW-1:0] MAXV = AW'((2 ** (DWIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] rnd;
    logic signed [AW-1:0] sh;

    // Multiply-accumulate, round half-up, then clamp to the sample range.
    always_comb begin
        acc = AW'(x0) * AW'(b0) + AW'(x1) * AW'(b1) + AW'(x2) * AW'(b2)
            + AW'(y1) * AW'(a1) + AW'(y2) * AW'(a2);
        rnd = acc + (AW'(1) <<< (FRAC - 1));
        sh  = rnd >>> FRAC;
        if (sh > MAXV)
            y0 = MAXV[DWIDTH-1:0];
        else if (sh < MINV)
            y0 = MINV[DWIDTH-1:0];
        else
            y0 = sh[DWIDTH-1:0];
    end
endmodule

module iir_order2_ctrl #(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              coef_we,
    input  logic [2:0]        coef_addr,
    input  logic [CWIDTH-1:0] coef_wdata,
    input  logic              coef_commit,
    input  logic              state_clr,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [DWIDTH-1:0] din,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DWIDTH-1:0] dout,
    output logic              coef_pending
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    // Bank entry order: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
    logic [1:0]             state_q, state_d;
    logic [DWIDTH-1:0]      x_r_q, x_r_d;
    logic [DWIDTH-1:0]      x1_q, x1_d, x2_q, x2_d;
    logic [DWIDTH-1:0]      y1_q, y1_d, y2_q, y2_d;
    logic [DWIDTH-1:0]      dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   pending_q, pending_d;
    logic [4:0][CWIDTH-1:0] shadow_q, shadow_d;
    logic [4:0][CWIDTH-1:0] active_q, active_d;
    logic signed [DWIDTH-1:0] core_y0;

    iir_order2 #(.DWIDTH(DWIDTH), .CWIDTH(CWIDTH)) u_core (
        .x0(x_r_q), .x1(x1_q), .x2(x2_q), .y1(y1_q), .y2(y2_q),
        .b0(active_q[0]), .b1(active_q[1]), .b2(active_q[2]),
        .a1(active_q[3]), .a2(active_q[4]),
        .y0(core_y0)
    );

    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign coef_pending = pending_q;

    // Next-state logic: sample sequencing, delay line, coefficient banks.
    always_comb begin
        state_d      = state_q;
        x_r_d        = x_r_q;
        x1_d         = x1_q;
        x2_d         = x2_q;
        y1_d         = y1_q;
        y2_d         = y2_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        pending_d    = pending_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        din_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    x_r_d   = din;
                    state_d = CALC;
                end
            end
            CALC: begin
                dout_d       = core_y0;
                dout_valid_d = 1'b1;
                x2_d         = x1_q;
                x1_d         = x_r_q;
                y2_d         = y1_q;
                y1_d         = core_y0;
                state_d      = OUT;
            end
            OUT: begin
                // Accepting while the held result drains keeps 1 sample / 2 cycles.
                din_ready = dout_ready;
                if (dout_ready) begin
                    if (din_valid) begin
                        x_r_d   = din;
                        state_d = CALC;
                    end else begin
                        dout_valid_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over the CALC shift; dout still gets the pre-clear result.
        if (state_clr) begin
            x1_d = '0;
            x2_d = '0;
            y1_d = '0;
            y2_d = '0;
        end

        // Addresses 5..7 match no entry and are dropped.
        if (coef_we) begin
            for (int i = 0; i < 5; i++) begin
                if (coef_addr == 3'(i))
                    shadow_d[i] = coef_wdata;
            end
        end

        // Never swap on a CALC edge so one sample sees one coherent set.
        // A commit that arrives while one is already pending is absorbed.
        if (pending_q && (state_q != CALC)) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (coef_commit) begin
            pending_d = 1'b1;
        end
    end

    // State registers; reset drops any in-flight sample and pending commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_r_q        <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            y1_q         <= '0;
            y2_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            pending_q    <= 1'b0;
            shadow_q     <= '0;
            active_q     <= '0;
        end else begin
            state_q      <= state_d;
            x_r_q        <= x_r_d;
            x1_q         <= x1_d;
            x2_q         <= x2_d;
            y1_q         <= y1_d;
            y2_q         <= y2_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
        end
    end
endmodule

// File: tb/tb_iir_order2_ctrl.sv
// Directed bench for iir_order2_ctrl. A transaction-level model predicts every
// output from the filter equation. A negedge compare process checks the DUT
// against the model each cycle. Literal checks in the driver pin the model.
module tb_iir_order2_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [23:0] coef_wdata = '0;
    logic        coef_commit = 1'b0;
    logic        state_clr = 1'b0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [15:0] din = '0;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic [15:0] dout;
    logic        coef_pending;

    int total = 0;
    int bad = 0;

    iir_order2_ctrl #(.DWIDTH(16), .CWIDTH(24)) dut (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .coef_commit(coef_commit), .state_clr(state_clr),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
        .coef_pending(coef_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_calc: a sample was accepted last edge, so this edge produces its result.
    int          m_x, m_x1, m_x2, m_y1, m_y2;
    int          m_sh [5];
    int          m_act[5];
    logic        m_calc, m_vld, m_pend;
    logic [15:0] m_dout;
    logic        m_rdy, m_acc;
    int          m_y;

    function automatic int filt();
        longint acc;
        acc = longint'(m_act[0]) * m_x  + longint'(m_act[1]) * m_x1
            + longint'(m_act[2]) * m_x2 + longint'(m_act[3]) * m_y1
            + longint'(m_act[4]) * m_y2;
        acc = (acc + (longint'(1) << 20)) >>> 21;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    assign m_rdy = m_calc ? 1'b0 : (m_vld ? dout_ready : 1'b1);
    assign m_acc = din_valid && m_rdy;
    always_comb m_y = filt();

    // Model state advances on the same edges as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_x <= 0; m_x1 <= 0; m_x2 <= 0; m_y1 <= 0; m_y2 <= 0;
            m_calc <= 1'b0; m_vld <= 1'b0; m_pend <= 1'b0; m_dout <= '0;
            for (int i = 0; i < 5; i++) begin
                m_sh[i]  <= 0;
                m_act[i] <= 0;
            end
        end else begin
            if (m_calc) begin
                m_dout <= m_y[15:0];
                m_vld  <= 1'b1;
            end else if (m_vld && dout_ready && !m_acc) begin
                m_vld <= 1'b0;
            end
            if (state_clr) begin
                m_x1 <= 0; m_x2 <= 0; m_y1 <= 0; m_y2 <= 0;
            end else if (m_calc) begin
                m_x2 <= m_x1; m_x1 <= m_x; m_y2 <= m_y1; m_y1 <= m_y;
            end
            if (m_acc) m_x <= int'($signed(din));
            m_calc <= m_acc;
            if (coef_we && coef_addr < 3'd5)
                m_sh[coef_addr] <= int'($signed(coef_wdata));
            if (m_pend && !m_calc) begin
                m_act  <= m_sh;
                m_pend <= 1'b0;
            end else if (coef_commit) begin
                m_pend <= 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, after the driver has settled.
    always @(negedge clk) begin
        #2;
        chk("m_dout_valid", dout_valid, m_vld);
        chk("m_dout", dout, m_dout);
        chk("m_din_ready", din_ready, m_rdy);
        chk("m_coef_pending", coef_pending, m_pend);
    end

    // ---------------- driver ----------------
    task automatic wr(input logic [2:0] a, input logic [23:0] d);
        coef_we = 1'b1; coef_addr = a; coef_wdata = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Pulse commit, then give the copy edge.
    task automatic commit();
        coef_commit = 1'b1;
        @(negedge clk);
        coef_commit = 1'b0;
        @(negedge clk);
    endtask

    task automatic clr();
        state_clr = 1'b1;
        @(negedge clk);
        state_clr = 1'b0;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] e, input string nm);
        int n = 0;
        while (!din_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk({nm, "_ready_timeout"}, 0, 1);
        din_valid = 1'b1; din = x;
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_vld"}, dout_valid, 1);
        chk(nm, dout, e);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_din_ready", din_ready, 1);
        chk("rst_pending", coef_pending, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Passthrough with explicit latency check.
        wr(3'd0, 24'h200000);
        commit();
        din_valid = 1'b1; din = 16'h1234;
        @(negedge clk);
        din_valid = 1'b0;
        chk("pt_not_yet", dout_valid, 0);
        @(negedge clk);
        chk("pt_vld", dout_valid, 1);
        chk("pt_dout", dout, 16'h1234);

        // Pure one-sample delay; address 5 must be ignored.
        clr();
        wr(3'd0, 24'h000000);
        wr(3'd1, 24'h200000);
        wr(3'd5, 24'h123456);
        commit();
        send(16'h0100, 16'h0000, "dly0");
        send(16'h0200, 16'h0100, "dly1");
        send(16'h0300, 16'h0200, "dly2");

        // Recursion: y = x + 0.5*y1.
        clr();
        wr(3'd1, 24'h000000);
        wr(3'd0, 24'h200000);
        wr(3'd3, 24'h100000);
        commit();
        send(16'h4000, 16'h4000, "rec0");
        send(16'h0000, 16'h2000, "rec1");
        send(16'h0000, 16'h1000, "rec2");

        // Backpressure with passthrough coefficients.
        wr(3'd3, 24'h000000);
        commit();
        clr();
        dout_ready = 1'b0;
        din_valid = 1'b1; din = 16'h0AAA;
        @(negedge clk);
        din = 16'h0BBB;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", din_ready, 0);
            chk("bp_dout", dout, 16'h0AAA);
            chk("bp_vld", dout_valid, 1);
            @(negedge clk);
        end
        dout_ready = 1'b1;
        #1;
        chk("bp_release_ready", din_ready, 1);
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        chk("bp_next", dout, 16'h0BBB);

        // Commit arriving with the accept: in-flight sample keeps old b0.
        wr(3'd0, 24'h100000);
        din_valid = 1'b1; din = 16'h0400; coef_commit = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; coef_commit = 1'b0;
        chk("cm_pend_calc", coef_pending, 1);
        @(negedge clk);
        chk("cm_old_coef", dout, 16'h0400);
        chk("cm_pend_out", coef_pending, 1);
        @(negedge clk);
        chk("cm_pend_clr", coef_pending, 0);
        send(16'h0400, 16'h0200, "cm_new_coef");

        // state_clr during CALC, then reset in OUT.
        wr(3'd0, 24'h200000);
        wr(3'd1, 24'h200000);
        commit();
        clr();
        send(16'h0100, 16'h0100, "sc_prime");
        din_valid = 1'b1; din = 16'h0050;
        @(negedge clk);
        din_valid = 1'b0; state_clr = 1'b1;
        @(negedge clk);
        state_clr = 1'b0;
        chk("sc_pre_clear", dout, 16'h0150);
        send(16'h0010, 16'h0010, "sc_zero_hist");
        din_valid = 1'b1; din = 16'h0020; coef_commit = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; coef_commit = 1'b0;
        @(negedge clk);
        chk("rs_out_dout", dout, 16'h0030);
        chk("rs_out_pend", coef_pending, 1);
        rst_n = 1'b0;
        #1;
        chk("rs_vld", dout_valid, 0);
        chk("rs_dout", dout, 0);
        chk("rs_ready", din_ready, 1);
        chk("rs_pend", coef_pending, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(16'h0777, 16'h0000, "rs_zero_coef");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
